hazard_sb: RTL

HAZARD_SB -- requirements
Module: hazard_sb

---
 rtl/hazard_sb_pkg.sv | 32 +++
 rtl/hazard_sb_cnt.sv | 82 ++++++++
 rtl/hazard_sb.sv | 130 +++++++++++++
 3 files changed

// File: rtl/hazard_sb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_sb_pkg
//  Description : Shared constants and FSM state type for the hazard
//                scoreboard: default exception vector, ERET code and the
//                exception-sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package hazard_sb_pkg;

  // Default exception entry point (boot exception vector, BEV=1)
  localparam logic [31:0] EXC_VEC_DEF = 32'hBFC00380;

  // Exception code that means "return from exception": target comes from EPC
  localparam logic [31:0] ERET_CODE   = 32'h0000000E;

  // Exception sequencer states
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  // Pick the redirect target for a given exception code
  function automatic logic [31:0] exc_target(input logic [31:0] code,
                                             input logic [31:0] epc,
                                             input logic [31:0] vec);
    return (code == ERET_CODE) ? epc : vec;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_sb_cnt.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_sb_cnt
//  Description : Per-register latency counter array. Each cycle the array is
//                cleared, frozen, or decremented with per-lane loads taking
//                priority over the decrement. Provides 2*LANES read ports
//                (rs/rt per lane) and a busy summary.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_sb_cnt #(
  parameter  int NREG  = 32,
  parameter  int LATW  = 3,
  parameter  int LANES = 2,
  localparam int RW    = $clog2(NREG),
  localparam int NRD   = 2 * LANES
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   i_clear,
  input  logic                   i_freeze,
  input  logic [LANES-1:0]       i_ld_en,
  input  logic [LANES*RW-1:0]    i_ld_dst,
  input  logic [LANES*LATW-1:0]  i_ld_lat,
  input  logic [NRD*RW-1:0]      i_rd_idx,
  output logic [NRD*LATW-1:0]    o_rd_cnt,
  output logic                   o_busy
);

  logic [LATW-1:0] r_cnt [NREG];
  logic [LATW-1:0] w_nxt [NREG];

  // Next-state: clear > freeze > (load, younger lane last, else decrement)
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      w_nxt[r] = r_cnt[r];
      if (i_clear) begin
        w_nxt[r] = '0;
      end else if (!i_freeze) begin
        if (r_cnt[r] != '0) begin
          w_nxt[r] = r_cnt[r] - LATW'(1);
        end
        for (int l = 0; l < LANES; l++) begin
          if (i_ld_en[l] && (i_ld_dst[l*RW +: RW] == RW'(r))) begin
            w_nxt[r] = i_ld_lat[l*LATW +: LATW];
          end
        end
      end
    end
    // Register 0 never carries a pending result
    w_nxt[0] = '0;
  end

  // Counter state, asynchronously cleared
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int r = 0; r < NREG; r++) begin
        r_cnt[r] <= '0;
      end
    end else begin
      for (int r = 0; r < NREG; r++) begin
        r_cnt[r] <= w_nxt[r];
      end
    end
  end

  // Read ports: current counter value for each requested source
  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      o_rd_cnt[k*LATW +: LATW] = r_cnt[i_rd_idx[k*RW +: RW]];
    end
  end

  // Busy when any register still has a result in flight
  always_comb begin
    o_busy = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      o_busy = o_busy | (r_cnt[r] != '0);
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_sb.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_sb
//  Description : Scoreboard-based hazard unit for a 1- or 2-lane in-order
//                pipeline. Generates per-lane decode stalls from pending
//                register results and intra-group dependencies, and sequences
//                exceptions through a one-cycle flush followed by a PC
//                redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_sb
  import hazard_sb_pkg::*;
#(
  parameter  int          LANES   = 2,
  parameter  int          NREG    = 32,
  parameter  int          LATW    = 3,
  parameter  logic [31:0] EXC_VEC = EXC_VEC_DEF,
  localparam int          RW      = $clog2(NREG)
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [LANES*RW-1:0]   rs_d,
  input  logic [LANES*RW-1:0]   rt_d,
  input  logic [LANES-1:0]      iss_valid,
  input  logic [LANES-1:0]      iss_we,
  input  logic [LANES*RW-1:0]   iss_dst,
  input  logic [LANES*LATW-1:0] iss_lat,
  input  logic                  long_stall,
  input  logic                  except_valid,
  input  logic [31:0]           except_type,
  input  logic [31:0]           cp0_epc,
  output logic                  stall_f,
  output logic [LANES-1:0]      stall_d,
  output logic                  flush_all,
  output logic                  pc_redirect,
  output logic [31:0]           pc_except,
  output logic                  sb_busy
);

  state_e                  r_state;
  logic [31:0]             r_pc_except;
  logic [2*LANES*RW-1:0]   w_rd_idx;
  logic [2*LANES*LATW-1:0] w_rd_cnt;
  logic [LANES-1:0]        w_ld_en;
  logic [LANES-1:0]        w_hz;
  logic                    w_stall0;

  // Per-lane source lookup, load enables and scoreboard hazards
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [RW-1:0] w_rs;
    logic [RW-1:0] w_rt;
    assign w_rs = rs_d[i*RW +: RW];
    assign w_rt = rt_d[i*RW +: RW];
    assign w_rd_idx[(2*i)*RW   +: RW] = w_rs;
    assign w_rd_idx[(2*i+1)*RW +: RW] = w_rt;
    assign w_ld_en[i] = iss_valid[i] & iss_we[i] & (iss_dst[i*RW +: RW] != '0);
    assign w_hz[i] = ((w_rs != '0) & (w_rd_cnt[(2*i)*LATW   +: LATW] != '0)) |
                     ((w_rt != '0) & (w_rd_cnt[(2*i+1)*LATW +: LATW] != '0));
  end

  hazard_sb_cnt #(
    .NREG  (NREG),
    .LATW  (LATW),
    .LANES (LANES)
  ) u_cnt (
    .clk      (clk),
    .resetn   (resetn),
    .i_clear  (flush_all),
    .i_freeze (long_stall),
    .i_ld_en  (w_ld_en),
    .i_ld_dst (iss_dst),
    .i_ld_lat (iss_lat),
    .i_rd_idx (w_rd_idx),
    .o_rd_cnt (w_rd_cnt),
    .o_busy   (sb_busy)
  );

  assign w_stall0   = long_stall | w_hz[0];
  assign stall_d[0] = w_stall0;

  // Lane 1 also stalls on a same-group producer in lane 0, and whenever
  // lane 0 stalls, so it never issues ahead of the older instruction.
  if (LANES == 2) begin : g_two
    logic [RW-1:0] w_rs1;
    logic [RW-1:0] w_rt1;
    logic [RW-1:0] w_dst0;
    logic          w_intra;
    assign w_rs1   = rs_d[RW +: RW];
    assign w_rt1   = rt_d[RW +: RW];
    assign w_dst0  = iss_dst[RW-1:0];
    assign w_intra = iss_we[0] & (((w_rs1 != '0) & (w_rs1 == w_dst0)) |
                                  ((w_rt1 != '0) & (w_rt1 == w_dst0)));
    assign stall_d[1] = w_stall0 | w_hz[1] | w_intra;
  end

  assign stall_f     = w_stall0 | stall_d[LANES-1] | (r_state != ST_IDLE);
  assign flush_all   = (r_state == ST_FLUSH);
  assign pc_redirect = (r_state == ST_REDIRECT);
  assign pc_except   = r_pc_except;

  // Exception sequencer: IDLE -> FLUSH (1 cycle) -> REDIRECT until stall clears
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_pc_except <= EXC_VEC;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (except_valid) begin
            r_state     <= ST_FLUSH;
            r_pc_except <= exc_target(except_type, cp0_epc, EXC_VEC);
          end
        end
        ST_FLUSH: begin
          r_state <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          if (!long_stall) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
